// File: rtl/chunk_serializer_pkg.sv
// Shared types and helpers for the chunk serializer.
package chunk_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Counter width for n chunks, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/chunk_serializer.sv
// Accepts a REG_WIDTH-chunk word over valid/ready and emits it chunk 0 first.
// Optional last_o marker is enabled by defining CHUNK_SERIALIZER_LAST_EN.
module chunk_serializer
    import chunk_serializer_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter int unsigned REG_WIDTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [REG_WIDTH-1:0][CHUNK_WIDTH-1:0] data_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    output logic [CHUNK_WIDTH-1:0]                data_o,
    output logic                                  valid_o,
    input  logic                                  ready_i
`ifdef CHUNK_SERIALIZER_LAST_EN
    ,
    output logic                                  last_o
`endif
);

    localparam int unsigned WORD_W = CHUNK_WIDTH * REG_WIDTH;
    localparam int unsigned CNT_W  = cnt_width(REG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_shift;

    // The buffer shifts down one chunk per transfer, so the next chunk is always at the bottom.
    assign word_shift = word_buf >> CHUNK_WIDTH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            word_buf <= '0;
            ready_o  <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                    data_o  <= '0;
                    if (valid_i && ready_o) begin
                        state    <= SEND;
                        cnt      <= '0;
                        word_buf <= data_i;
                        ready_o  <= 1'b0;
                        valid_o  <= 1'b1;
                        data_o   <= data_i[0];
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                            valid_o <= 1'b0;
                            data_o  <= '0;
                        end else begin
                            cnt      <= CNT_W'(cnt + 1'b1);
                            word_buf <= word_shift;
                            data_o   <= word_shift[CHUNK_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b0;
                    valid_o <= 1'b0;
                    data_o  <= '0;
                end
            endcase
        end
    end

`ifdef CHUNK_SERIALIZER_LAST_EN
    // Registered alongside data_o so it marks the final chunk in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_o <= 1'b0;
        end else begin
            case (state)
                IDLE: last_o <= (valid_i && ready_o) ? (REG_WIDTH == 1) : 1'b0;
                SEND: begin
                    if (ready_i) begin
                        last_o <= (cnt != CNT_LAST) && (CNT_W'(cnt + 1'b1) == CNT_LAST);
                    end
                end
                default: last_o <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_chunk_serializer.sv
// Scoreboard bench for chunk_serializer (CHUNK_WIDTH=8, REG_WIDTH=4); build with
// CHUNK_SERIALIZER_LAST_EN defined to also check last_o.
module tb_chunk_serializer;

    localparam int unsigned CW = 8;
    localparam int unsigned RW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [RW-1:0][CW-1:0]  data_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [CW-1:0]          data_o;
    logic                   valid_o;
    logic                   ready_i;
`ifdef CHUNK_SERIALIZER_LAST_EN
    logic                   last_o;
`endif

    chunk_serializer #(.CHUNK_WIDTH(CW), .REG_WIDTH(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
`ifdef CHUNK_SERIALIZER_LAST_EN
        ,
        .last_o  (last_o)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [CW-1:0]      exp_q[$];
    logic [CW*RW-1:0]   word_q[$];
    logic [CW*RW-1:0]   sr = '0;
    int                 chunk_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted chunk and models a downstream shift register.
    always @(negedge clk) begin
        if (!rst_n) begin
            chunk_idx = 0;
            sr        = '0;
        end else if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_chunk: got %h expected no transfer", data_o);
            end else begin
                check("chunk", 32'(data_o), 32'(exp_q.pop_front()));
`ifdef CHUNK_SERIALIZER_LAST_EN
                check("last", 32'(last_o), 32'(chunk_idx == RW - 1));
`endif
                sr = {data_o, sr[CW*RW-1:CW]};
                chunk_idx++;
                if (chunk_idx == RW) begin
                    chunk_idx = 0;
                    if (word_q.size() > 0) check("shift_reg_word", sr, word_q.pop_front());
                end
            end
        end
    end

    // Presents a word, waits for ready_o, pushes expectations, and returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        int n;
        n       = 0;
        valid_i = 1'b1;
        data_i  = w;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got ready_o=0 expected ready_o=1 within 50 cycles");
            valid_i = 1'b0;
            return;
        end
        for (int i = 0; i < int'(RW); i++) exp_q.push_back(w[i*CW +: CW]);
        word_q.push_back(w);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_i  = '1;
    endtask

    // Waits until every expected chunk has been transferred, then checks the return to idle.
    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_valid_o", 32'(valid_o), 32'd0);
        check("idle_ready_o", 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;

        // Reset
        @(posedge clk); #1;
        check("rst_ready_o", 32'(ready_o), 32'd0);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
`ifdef CHUNK_SERIALIZER_LAST_EN
        check("rst_last_o", 32'(last_o), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready_o", 32'(ready_o), 32'd1);
        check("post_rst_valid_o", 32'(valid_o), 32'd0);
        check("post_rst_data_o", 32'(data_o), 32'd0);

        // Basic word, chunk 0 valid the cycle after acceptance
        send_word(32'hDDCCBBAA);
        check("lat_valid_o", 32'(valid_o), 32'd1);
        check("lat_data_o", 32'(data_o), 32'hAA);
        check("lat_ready_o", 32'(ready_o), 32'd0);
        drain();

        // Reassembly through the downstream shift register model
        send_word(32'h44332211);
        drain();

        // Downstream stall while BB is presented
        send_word(32'hDDCCBBAA);
        @(posedge clk); #1;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data_o", 32'(data_o), 32'hBB);
            check("stall_valid_o", 32'(valid_o), 32'd1);
        end
        ready_i = 1'b1;
        drain();

        // Second word presented while the first is still sending
        send_word(32'h11223344);
        send_word(32'h87654321);
        drain();

        // Reset mid-word after BB has transferred
        send_word(32'hDDCCBBAA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        word_q.delete();
        @(posedge clk); #1;
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_ready_o", 32'(ready_o), 32'd0);
        check("midrst_data_o", 32'(data_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready_o", 32'(ready_o), 32'd1);
        check("rel_valid_o", 32'(valid_o), 32'd0);

        // Recovery after reset
        send_word(32'h0D0C0B0A);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
